// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   state_t           : freeze FSM encoding (RUN, MEM_WAIT)
//   FWD_RF/FWD_W/FWD_M: operand forward-select codes
//   REG_X0            : index of the hard-wired zero register
package pipeline_hazard_ctrl_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/hazard_fwd_unit.sv
// Combinational forwarding compare for one Execute-stage source operand.
// Ports:
//   rs_e        : Execute-stage source register
//   rd_m, rd_w  : Memory / Writeback destination registers
//   reg_write_m : Memory-stage instruction writes rd_m
//   reg_write_w : Writeback-stage instruction writes rd_w
//   fwd_sel     : FWD_M, FWD_W or FWD_RF
module hazard_fwd_unit
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic [4:0] rs_e,
  input  logic [4:0] rd_m,
  input  logic [4:0] rd_w,
  input  logic       reg_write_m,
  input  logic       reg_write_w,
  output logic [1:0] fwd_sel
);

  logic hit_m;
  logic hit_w;

  // x0 is constant zero, so a write to it never produces a value to forward.
  assign hit_m = reg_write_m && (rd_m != REG_X0) && (rd_m == rs_e);
  assign hit_w = reg_write_w && (rd_w != REG_X0) && (rd_w == rs_e);

  // The M-stage result is younger than the W-stage one, so it wins.
  always_comb begin
    fwd_sel = FWD_RF;
    if (hit_m) begin
      fwd_sel = FWD_M;
    end else if (hit_w) begin
      fwd_sel = FWD_W;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for a 5-stage pipeline: operand forwarding, load-use
// stall, branch flush, data-memory freeze with timeout, and performance
// counters.
// Ports:
//   clk, rst                       : clock, async active-high reset
//   RS1_D, RS2_D                   : Decode-stage source registers
//   RS1_E, RS2_E, RD_E             : Execute-stage sources / destination
//   RD_M, RD_W                     : Memory / Writeback destinations
//   ResultSrcE                     : Execute-stage instruction is a load
//   RegWriteM, RegWriteW           : register write enables in M and W
//   PCSrcE                         : branch/jump taken in Execute
//   mem_busy                       : data memory requests a freeze
//   ForwardAE, ForwardBE           : operand forward selects
//   StallF/D/E/M, FlushD, FlushE   : pipeline register controls
//   mem_timeout                    : sticky freeze-timeout flag
//   cyc_cnt, stall_cnt, flush_cnt  : saturating performance counters
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       RS1_D,
  input  logic [4:0]       RS2_D,
  input  logic [4:0]       RS1_E,
  input  logic [4:0]       RS2_E,
  input  logic [4:0]       RD_E,
  input  logic [4:0]       RD_M,
  input  logic [4:0]       RD_W,
  input  logic             ResultSrcE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             PCSrcE,
  input  logic             mem_busy,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // TIMEOUT is expected to be at least 1.
  localparam int                WAIT_W   = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  // ---------------------------------------------------------------- forwarding
  logic [4:0] src_e   [2];
  logic [1:0] fwd_sel [2];

  assign src_e[0] = RS1_E;
  assign src_e[1] = RS2_E;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      hazard_fwd_unit u_fwd (
        .rs_e        (src_e[gi]),
        .rd_m        (RD_M),
        .rd_w        (RD_W),
        .reg_write_m (RegWriteM),
        .reg_write_w (RegWriteW),
        .fwd_sel     (fwd_sel[gi])
      );
    end
  endgenerate

  assign ForwardAE = rst ? FWD_RF : fwd_sel[0];
  assign ForwardBE = rst ? FWD_RF : fwd_sel[1];

  // ---------------------------------------------------------------- hazards
  state_t            state_reg;
  state_t            state_next;
  logic              branch_pend_reg;
  logic              branch_pend_next;
  logic [WAIT_W-1:0] wait_cnt_reg;
  logic [WAIT_W-1:0] wait_cnt_next;
  logic              mem_timeout_reg;
  logic              mem_timeout_next;
  logic              load_use;
  logic              branch_eff;

  assign load_use = ResultSrcE && (RD_E != REG_X0) &&
                    ((RD_E == RS1_D) || (RD_E == RS2_D));

  // A branch resolved while frozen stays in the frozen E stage; remember it
  // so the flush still happens on the first unfrozen cycle even if PCSrcE
  // has been dropped by then.
  assign branch_eff       = PCSrcE || branch_pend_reg;
  assign branch_pend_next = mem_busy ? (branch_pend_reg || PCSrcE) : 1'b0;

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM: next state
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN:      if (mem_busy)  state_next = MEM_WAIT;
      MEM_WAIT: if (!mem_busy) state_next = RUN;
      default:  state_next = RUN;
    endcase
  end

  // FSM: outputs. Freeze beats branch flush beats load-use stall. The freeze
  // follows mem_busy directly so it takes effect in the requesting cycle.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    if (!rst) begin
      if (mem_busy) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
      end else if (branch_eff) begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else if (load_use) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
    end
  end

  // Wait counter counts frozen cycles spent in MEM_WAIT and saturates.
  always_comb begin
    wait_cnt_next = '0;
    if (state_reg == MEM_WAIT && mem_busy) begin
      wait_cnt_next = (wait_cnt_reg == WAIT_MAX) ? WAIT_MAX
                                                 : wait_cnt_reg + WAIT_W'(1);
    end
    mem_timeout_next = mem_timeout_reg || (wait_cnt_next == WAIT_MAX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_pend_reg <= 1'b0;
      wait_cnt_reg    <= '0;
      mem_timeout_reg <= 1'b0;
    end else begin
      branch_pend_reg <= branch_pend_next;
      wait_cnt_reg    <= wait_cnt_next;
      mem_timeout_reg <= mem_timeout_next;
    end
  end

  assign mem_timeout = mem_timeout_reg;

  // ---------------------------------------------------------------- counters
  logic [CNT_W-1:0] cyc_cnt_reg;
  logic [CNT_W-1:0] stall_cnt_reg;
  logic [CNT_W-1:0] flush_cnt_reg;

  // FlushD is only ever raised by a branch, so it marks branch flushes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_cnt_reg   <= '0;
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (cyc_cnt_reg != CNT_MAX) begin
        cyc_cnt_reg <= cyc_cnt_reg + CNT_W'(1);
      end
      if (StallF && stall_cnt_reg != CNT_MAX) begin
        stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
      end
      if (FlushD && FlushE && flush_cnt_reg != CNT_MAX) begin
        flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
      end
    end
  end

  assign cyc_cnt   = cyc_cnt_reg;
  assign stall_cnt = stall_cnt_reg;
  assign flush_cnt = flush_cnt_reg;

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 255: maximum consecutive mem_busy cycles before the error flag.
REQ-002 The block SHALL have parameter CNT_W, default 32: width of the performance counters.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have inputs RS1_D and RS2_D, 5 bits each: Decode-stage source registers.
REQ-006 The block SHALL have inputs RS1_E, RS2_E and RD_E, 5 bits each: Execute-stage source and destination registers.
REQ-007 The block SHALL have inputs RD_M and RD_W, 5 bits each: Memory-stage and Writeback-stage destinations.
REQ-008 The block SHALL have input ResultSrcE, 1 bit: the Execute-stage instruction is a load.
REQ-009 The block SHALL have inputs RegWriteM and RegWriteW, 1 bit each: register-write enables in M and W.
REQ-010 The block SHALL have input PCSrcE, 1 bit: branch or jump taken, resolved in Execute.
REQ-011 The block SHALL have input mem_busy, 1 bit: the data memory requests a pipeline freeze.
REQ-012 The block SHALL have outputs ForwardAE and ForwardBE, 2 bits each: operand select, 00 register file, 10 from M, 01 from W.
REQ-013 The block SHALL have outputs StallF, StallD, StallE, StallM, FlushD and FlushE, 1 bit each: pipeline register controls.
REQ-014 The block SHALL have output mem_timeout, 1 bit: sticky error flag.
REQ-015 The block SHALL have outputs cyc_cnt, stall_cnt and flush_cnt, CNT_W bits each: performance counters.

Function
REQ-016 Forwarding SHALL select 10 when RegWriteM=1, RD_M!=0 and RD_M equals the source register (RS1_E for ForwardAE, RS2_E for ForwardBE).
REQ-017 Otherwise forwarding SHALL select 01 when RegWriteW=1, RD_W!=0 and RD_W equals the source register; otherwise 00; forwarding is combinational.
REQ-018 The M-stage match SHALL take priority over the W-stage match when both hit.
REQ-019 Register x0 SHALL never be forwarded.
REQ-020 Load-use is detected when ResultSrcE=1, RD_E!=0 and RD_E equals RS1_D or RS2_D.
REQ-021 On load-use, StallF=1, StallD=1 and FlushE=1 for that cycle; the stall lasts exactly one cycle per hazard.
REQ-022 On PCSrcE=1, FlushD=1 and FlushE=1 in the same cycle, and StallF and StallD SHALL be 0.
REQ-023 The FSM SHALL have states RUN and MEM_WAIT; the state is registered.
REQ-024 In RUN, mem_busy=1 SHALL move the FSM to MEM_WAIT at the next edge.
REQ-025 In MEM_WAIT, mem_busy=0 SHALL return the FSM to RUN at the next edge.
REQ-026 StallF, StallD, StallE and StallM SHALL be 1 whenever mem_busy=1 in either state, combinationally; all flushes SHALL then be 0.
REQ-027 Control priority SHALL be: mem_busy freeze, then branch flush, then load-use stall.
REQ-028 A branch taken during a freeze SHALL be held by the frozen E stage and its flush applied on the first unfrozen cycle.
REQ-029 The wait counter SHALL count consecutive MEM_WAIT cycles and clear on return to RUN.
REQ-030 When the wait counter reaches TIMEOUT, mem_timeout SHALL set and remain set until reset; the wait counter saturates.
REQ-031 cyc_cnt SHALL increment every cycle.
REQ-032 stall_cnt SHALL increment in any cycle with StallF=1.
REQ-033 flush_cnt SHALL increment in any cycle with FlushD=1 and FlushE=1 driven by a branch.
REQ-034 All three performance counters SHALL saturate at all-ones and not wrap.

Reset
REQ-035 While rst=1, the FSM SHALL be in RUN, and the counters and mem_timeout SHALL be 0.
REQ-036 While rst=1, all stall and flush outputs SHALL be 0, and ForwardAE and ForwardBE SHALL be 00.
REQ-037 Reset asserted mid-MEM_WAIT SHALL abort the wait immediately, asynchronously.

Structure
REQ-038 A shared package SHALL hold the state encoding (RUN, MEM_WAIT), the forward-select constants FWD_RF=00, FWD_W=01 and FWD_M=10, and the x0 index.
REQ-039 One sub-module, hazard_fwd_unit, SHALL hold the pure combinational forwarding compare, instantiated once per operand.

Verification
REQ-040 Bench SHALL drive RegWriteM=1, RD_M=1, RS1_E=1 with RegWriteW=1, RD_W=1 -> ForwardAE=10.
REQ-041 Bench SHALL drive RD_M=0 matching RS1_E=0 -> ForwardAE=00.
REQ-042 Bench SHALL drive ResultSrcE=1, RD_E=2, RS2_D=2 for one cycle -> StallF=1, StallD=1, FlushE=1 for that cycle only, and stall_cnt +1.
REQ-043 Bench SHALL raise PCSrcE=1 together with a load-use hazard -> FlushD=1, FlushE=1, StallF=0, and flush_cnt +1.
REQ-044 Bench SHALL hold mem_busy=1 for 3 cycles with PCSrcE=1 -> all four stalls high for 3 cycles, no flush, then FlushD=1 and FlushE=1 in cycle 4.
REQ-045 Bench SHALL use TIMEOUT=4, hold mem_busy for 6 cycles, then assert rst mid-wait -> mem_timeout=1 after the 4th wait cycle, and all outputs 0 immediately on rst.
